seq_mult_unit: RTL and testbench
================================

# seq_mult_unit

Parametrised sequential shift-and-add multiplier: a 3-state control FSM and its datapath in one block. Multiplies two WIDTH-bit operands, signed or unsigned, one multiplier bit per clock. It uses a valid_data/ack handshake and holds the product until the consumer acknowledges it. It is the next generation of the team's fixed-width multiplier controller and is instantiated directly by the arithmetic unit.

## Interface
- WIDTH, 8, operand width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH), iteration counter width; derived, never overridden.

- Clock  in  1  system clock; all state updates on the rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- valid_data  in  1  operands valid; sampled only in IDLE.
- signed_op  in  1  1 = operands are two's complement; sampled together with the operands.
- A  in  WIDTH  multiplicand.
- B  in  WIDTH  multiplier.
- ack  in  1  consumer has read Product; sampled only in DONE.
- Product  out  2*WIDTH  result, registered.
- done  out  1  Product valid; high for the whole time the FSM is in DONE.
- busy  out  1  high in CALC and DONE, i.e. not accepting operands.

## Operation
- States: IDLE=0, CALC=1, DONE=2. Encoding 3 is illegal and goes to IDLE on the next edge with the outputs unchanged.
- IDLE, valid_data=0: stay in IDLE.
- IDLE, valid_data=1, on the capture edge:
  - a_reg (2*WIDTH bits) <= A, sign-extended if signed_op=1, otherwise zero-extended.
  - b_reg <= B; sgn <= signed_op; cnt <= 0; Product <= 0.
  - Go to CALC.
- CALC, every edge:
  - If b_reg[0]=1: Product <= Product + a_reg. On the last iteration (cnt=WIDTH-1) with sgn=1, subtract instead (MSB weight is negative).
  - a_reg <<= 1; b_reg >>= 1 (logical); cnt++.
- CALC exit: go to DONE on the edge where cnt=WIDTH-1. The early-exit condition is in Configuration.
- DONE:
  - ack=0: stay; Product is frozen.
  - ack=1: go to IDLE. Product is still held.
- Arithmetic: all adds and subtracts are modulo 2^(2*WIDTH). The result is exact for both modes.
- valid_data while busy=1 is ignored; no queuing.
- ack outside DONE is ignored.
- Reset_n low at any time, including mid-CALC: state=IDLE, Product=0, done=0, busy=0, internal registers cleared. Any in-flight operation is lost.

## Timing
- Reset values: Product=0, done=0, busy=0.
- Capture edge: busy rises after it.
- Latency (capture edge to done high): exactly WIDTH edges without early exit; see Configuration for early exit.
- ack high at edge k while in DONE: done and busy are low after edge k.
- Back-to-back operations: valid_data high at edge k+1 captures new operands. Minimum gap between operations is one IDLE cycle.
- All outputs are registered; there is no combinational path from any input to any output.

## Configuration
- EARLY_TERM_EN defined:
  - CALC also goes to DONE on the edge where the shifted b_reg becomes 0.
  - Latency = max(1, index of the highest set bit of B + 1).
  - B=0 gives a latency of 1.
  - Signed negative B always takes WIDTH cycles (its MSB is set).
- EARLY_TERM_EN undefined: latency is always exactly WIDTH cycles, data-independent.
- The Product value is identical in both builds.

## Test plan
All cases use WIDTH=8.
- Unsigned: A=13, B=11, signed_op=0 -> Product=0x008F. done after 8 cycles; after 4 with EARLY_TERM_EN.
- Unsigned max: A=255, B=255 -> Product=0xFE01 after 8 cycles in both builds.
- Signed: A=0xFD (-3), B=0x05, signed_op=1 -> Product=0xFFF1 (-15). Also A=0x80, B=0x80 -> 0x4000 after 8 cycles.
- B=0, A=0x5A -> Product=0x0000. Latency 1 with EARLY_TERM_EN, 8 without.
- Handshake: ack held low 20 cycles in DONE while valid_data toggles.
  - Required: done and Product stable, no new capture.
  - ack=1 -> done=0 next cycle.
  - valid_data on the following edge starts a new operation.
- Reset mid-CALC: Reset_n low at iteration 3 -> Product=0, done=0, busy=0 immediately. The next operation after release is correct.

Source files
------------

// File: rtl/seq_mult_unit.sv
//
// seq_mult_unit
// -------------
// Sequential shift-and-add multiplier with a three-state control FSM
// (IDLE -> CALC -> DONE) and its datapath in one block. Each CALC cycle
// consumes one multiplier bit. Signed operands use the two's complement
// rule that the multiplier MSB carries negative weight, so the final
// partial product is subtracted rather than added. The product is held
// in DONE until the consumer acknowledges it.
//
// Optional feature macro: EARLY_TERM_EN
//   When defined, CALC also ends as soon as the remaining multiplier bits
//   are all zero, so latency tracks the highest set bit of B.
//   When undefined, latency is always WIDTH cycles.
//
// Parameters:
//   WIDTH   operand width in bits (2..32)
//   CNT_W   iteration counter width, derived from WIDTH
//
// Ports:
//   Clock       in   system clock, rising edge
//   Reset_n     in   asynchronous active-low reset
//   valid_data  in   operands valid, sampled only in IDLE
//   signed_op   in   1 = two's complement operands, sampled with A/B
//   A           in   multiplicand [WIDTH-1:0]
//   B           in   multiplier   [WIDTH-1:0]
//   ack         in   consumer has read Product, sampled only in DONE
//   Product     out  registered result [2*WIDTH-1:0]
//   done        out  Product valid (high throughout DONE)
//   busy        out  high in CALC and DONE
//
module seq_mult_unit #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic                 Clock,
    input  logic                 Reset_n,
    input  logic                 valid_data,
    input  logic                 signed_op,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic                 ack,
    output logic [2*WIDTH-1:0]   Product,
    output logic                 done,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t               state;
    logic [2*WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]     b_reg;
    logic                 sgn;
    logic [CNT_W-1:0]     cnt;

    logic                 last_iter;
    logic                 calc_exit;

    // The final iteration is the one processing the multiplier MSB; with
    // signed operands that bit has weight -2^(WIDTH-1).
    assign last_iter = (cnt == LAST_CNT);

`ifdef EARLY_TERM_EN
    // Leave CALC once no set bits remain above the one being processed now.
    assign calc_exit = last_iter || (b_reg[WIDTH-1:1] == '0);
`else
    assign calc_exit = last_iter;
`endif

    // Control FSM and datapath. done/busy are registered alongside the
    // state so that no input reaches an output combinationally.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state   <= IDLE;
            a_reg   <= '0;
            b_reg   <= '0;
            sgn     <= 1'b0;
            cnt     <= '0;
            Product <= '0;
            done    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid_data) begin
                        // Extend A to full product width so the shifted
                        // partial products stay correct modulo 2^(2*WIDTH).
                        if (signed_op)
                            a_reg <= {{WIDTH{A[WIDTH-1]}}, A};
                        else
                            a_reg <= {{WIDTH{1'b0}}, A};
                        b_reg   <= B;
                        sgn     <= signed_op;
                        cnt     <= '0;
                        Product <= '0;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                        state   <= CALC;
                    end
                end

                CALC: begin
                    if (b_reg[0]) begin
                        if (last_iter && sgn)
                            Product <= Product - a_reg;
                        else
                            Product <= Product + a_reg;
                    end
                    a_reg <= a_reg << 1;
                    b_reg <= b_reg >> 1;
                    cnt   <= cnt + CNT_W'(1);
                    if (calc_exit) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end

                DONE: begin
                    if (ack) begin
                        done  <= 1'b0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end

                default: begin
                    // Unused encoding: recover to IDLE, outputs untouched.
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mult_unit.sv
//
// tb_seq_mult_unit
// ----------------
// Scoreboard bench for seq_mult_unit (WIDTH=8). The driver pushes the
// expected product and latency for every issued operation; a monitor
// pops and compares whenever done rises and watches that Product stays
// frozen while done is held.
//
module tb_seq_mult_unit;

    localparam int W = 8;

    logic             Clock;
    logic             Reset_n;
    logic             valid_data;
    logic             signed_op;
    logic [W-1:0]     A;
    logic [W-1:0]     B;
    logic             ack;
    logic [2*W-1:0]   Product;
    logic             done;
    logic             busy;

    typedef struct {
        logic [2*W-1:0] product;
        int             lat;
    } exp_t;

    exp_t sb[$];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    seq_mult_unit #(.WIDTH(W)) dut (
        .Clock      (Clock),
        .Reset_n    (Reset_n),
        .valid_data (valid_data),
        .signed_op  (signed_op),
        .A          (A),
        .B          (B),
        .ack        (ack),
        .Product    (Product),
        .done       (done),
        .busy       (busy)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    initial forever begin
        @(posedge Clock);
        cyc++;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference product: plain integer multiplication, truncated.
    function automatic logic [2*W-1:0] ref_product(input logic [W-1:0] a,
                                                   input logic [W-1:0] b,
                                                   input logic s);
        logic signed [63:0] p;
        if (s)
            p = 64'(signed'(a)) * 64'(signed'(b));
        else
            p = {56'd0, a} * {56'd0, b};
        return p[2*W-1:0];
    endfunction

    // Reference latency from the position of B's highest set bit.
    function automatic int ref_latency(input logic [W-1:0] b);
        int hi;
        hi = -1;
        for (int i = 0; i < W; i++)
            if (b[i]) hi = i;
`ifdef EARLY_TERM_EN
        return (hi < 0) ? 1 : hi + 1;
`else
        return W;
`endif
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: compares at every done rising edge and checks the hold.
    initial begin
        logic           busy_prev;
        logic           done_prev;
        int             cap_cyc;
        logic [2*W-1:0] cur_exp;
        exp_t           e;
        busy_prev = 1'b0;
        done_prev = 1'b0;
        cap_cyc   = 0;
        cur_exp   = '0;
        forever begin
            @(negedge Clock);
            if (!Reset_n) begin
                busy_prev = 1'b0;
                done_prev = 1'b0;
            end else begin
                if (busy && !busy_prev)
                    cap_cyc = cyc;
                if (done && !done_prev) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_done: got done with empty scoreboard, required no result");
                    end else begin
                        e = sb.pop_front();
                        checkOutput("product", 64'(Product), 64'(e.product));
                        checkOutput("latency", 64'(cyc - cap_cyc), 64'(e.lat));
                        cur_exp = e.product;
                    end
                end else if (done && done_prev) begin
                    checkOutput("product_hold", 64'(Product), 64'(cur_exp));
                end
                busy_prev = busy;
                done_prev = done;
            end
        end
    end

    // Issue one operation, hold ack low for hold cycles (valid_data
    // toggling meanwhile), then acknowledge. Called at posedge+1.
    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic s, input int hold);
        exp_t e;
        int   n;
        A          = a;
        B          = b;
        signed_op  = s;
        valid_data = 1'b1;
        e.product  = ref_product(a, b, s);
        e.lat      = ref_latency(b);
        sb.push_back(e);
        @(posedge Clock);
        #1;
        valid_data = 1'b0;
        checkOutput("busy_after_capture", 64'(busy), 64'd1);

        n = 0;
        while (!done && n < 4 * W) begin
            @(posedge Clock);
            #1;
            n++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL done_timeout: got done=0 after %0d cycles, required done=1", n);
            Reset_n = 1'b0;
            #1;
            sb.delete();
            @(posedge Clock);
            #1;
            Reset_n = 1'b1;
            return;
        end

        for (int i = 0; i < hold; i++) begin
            valid_data = 1'($urandom);
            A          = W'($urandom);
            B          = W'($urandom);
            signed_op  = 1'($urandom);
            @(posedge Clock);
            #1;
        end
        valid_data = 1'b0;
        if (hold > 0) begin
            checkOutput("done_held", 64'(done), 64'd1);
            checkOutput("busy_held", 64'(busy), 64'd1);
        end

        ack = 1'b1;
        @(posedge Clock);
        #1;
        ack = 1'b0;
        checkOutput("done_after_ack", 64'(done), 64'd0);
        checkOutput("busy_after_ack", 64'(busy), 64'd0);
    endtask

    initial begin
        exp_t dummy;
        Reset_n    = 1'b0;
        valid_data = 1'b0;
        signed_op  = 1'b0;
        A          = '0;
        B          = '0;
        ack        = 1'b0;

        @(posedge Clock);
        #1;
        checkOutput("reset_product", 64'(Product), 64'd0);
        checkOutput("reset_done", 64'(done), 64'd0);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        @(posedge Clock);
        #1;
        Reset_n = 1'b1;
        @(posedge Clock);
        #1;

        // Directed cases
        applyStimulus(8'd13,  8'd11,  1'b0, 0);
        applyStimulus(8'd255, 8'd255, 1'b0, 1);
        applyStimulus(8'hFD,  8'h05,  1'b1, 0);
        applyStimulus(8'h80,  8'h80,  1'b1, 2);
        applyStimulus(8'h5A,  8'h00,  1'b0, 0);
        applyStimulus(8'h7F,  8'hFF,  1'b1, 0);

        // Long hold in DONE with valid_data toggling, then back-to-back op
        applyStimulus(8'h37,  8'hC9,  1'b1, 20);
        applyStimulus(8'h21,  8'h03,  1'b0, 0);

        // Reset in the middle of CALC
        A          = 8'h99;
        B          = 8'hF7;
        signed_op  = 1'b0;
        valid_data = 1'b1;
        dummy.product = ref_product(8'h99, 8'hF7, 1'b0);
        dummy.lat     = ref_latency(8'hF7);
        sb.push_back(dummy);
        @(posedge Clock);
        #1;
        valid_data = 1'b0;
        repeat (3) begin
            @(posedge Clock);
            #1;
        end
        Reset_n = 1'b0;
        #1;
        void'(sb.pop_back());
        checkOutput("midcalc_reset_product", 64'(Product), 64'd0);
        checkOutput("midcalc_reset_done", 64'(done), 64'd0);
        checkOutput("midcalc_reset_busy", 64'(busy), 64'd0);
        @(posedge Clock);
        #1;
        Reset_n = 1'b1;
        @(posedge Clock);
        #1;
        applyStimulus(8'h12, 8'h34, 1'b0, 0);

        // Randomized operations
        for (int k = 0; k < 40; k++)
            applyStimulus(W'($urandom), W'($urandom), 1'($urandom),
                          int'($urandom_range(0, 3)));

        repeat (3) @(posedge Clock);
        #1;
        checkOutput("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
